// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared definitions for the pipeline control sequencer: wait-FSM encoding,
// parameter defaults and the packed control-output bundle.
package pipeline_ctrl_unit_pkg;

  typedef enum logic {
    PCU_RUN      = 1'b0,
    PCU_MEM_WAIT = 1'b1
  } pcu_state_e;

  localparam int unsigned PCU_MEM_TIMEOUT_DEF = 64;
  localparam int unsigned PCU_CNT_W_DEF       = 16;

  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_exe_freeze;
    logic id_exe_bubble;
    logic exe_mem_freeze;
    logic mem_wb_bubble;
  } pcu_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_unit_sat_counter.sv
// Saturating up-counter with increment enable; the synchronous clear wins
// over an increment in the same cycle.
module sat_counter
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int unsigned CNT_W = PCU_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline control sequencer: priority mux for freeze/flush/bubble, SRAM wait
// FSM with sticky timeout watchdog, and saturating performance counters.
module pipeline_ctrl_unit
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = PCU_MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = PCU_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             perf_clr,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_exe_freeze,
  output logic             id_exe_bubble,
  output logic             exe_mem_freeze,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int unsigned     WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  pcu_state_e        state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_timeout_q;
  logic              mem_stall_s;
  logic              sel_branch_s;
  logic              sel_hazard_s;
  logic              cnt_clr_s;
  pcu_ctrl_t         ctrl_s;

  assign mem_stall_s = mem_req & ~sram_ready;

  // Priority select: memory wait, then taken branch, then RAW hazard.
  always_comb begin
    ctrl_s       = '0;
    sel_branch_s = 1'b0;
    sel_hazard_s = 1'b0;
    if (rst) begin
      ctrl_s = '0;
    end else if (mem_stall_s) begin
      ctrl_s.pc_freeze      = 1'b1;
      ctrl_s.if_id_freeze   = 1'b1;
      ctrl_s.id_exe_freeze  = 1'b1;
      ctrl_s.exe_mem_freeze = 1'b1;
      ctrl_s.mem_wb_bubble  = 1'b1;
    end else if (branch_taken) begin
      sel_branch_s          = 1'b1;
      ctrl_s.if_id_flush    = 1'b1;
      ctrl_s.id_exe_bubble  = 1'b1;
    end else if (hazard_detected) begin
      sel_hazard_s          = 1'b1;
      ctrl_s.pc_freeze      = 1'b1;
      ctrl_s.if_id_freeze   = 1'b1;
      ctrl_s.id_exe_bubble  = 1'b1;
    end else begin
      ctrl_s = '0;
    end
  end

  // Wait FSM, wait-cycle counter and sticky watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PCU_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        PCU_RUN: begin
          if (mem_stall_s) state_q <= PCU_MEM_WAIT;
          else             state_q <= PCU_RUN;
        end
        PCU_MEM_WAIT: begin
          if (sram_ready || !mem_req) state_q <= PCU_RUN;
          else                        state_q <= PCU_MEM_WAIT;
        end
        default: state_q <= PCU_RUN;
      endcase
      // Saturate at MEM_TIMEOUT so an endless wait never wraps the counter.
      if (!mem_stall_s) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_q <= wait_cnt_q;
      end
      if (mem_stall_s && (wait_cnt_q == WAIT_LAST)) mem_timeout_q <= 1'b1;
      else                                          mem_timeout_q <= mem_timeout_q;
    end
  end

  assign cnt_clr_s = rst | perf_clr;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (cnt_clr_s),
    .inc_i (sel_hazard_s),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (cnt_clr_s),
    .inc_i (sel_branch_s),
    .cnt_o (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .clr_i (cnt_clr_s),
    .inc_i (mem_stall_s),
    .cnt_o (memwait_cnt)
  );

  assign pc_freeze      = ctrl_s.pc_freeze;
  assign if_id_freeze   = ctrl_s.if_id_freeze;
  assign if_id_flush    = ctrl_s.if_id_flush;
  assign id_exe_freeze  = ctrl_s.id_exe_freeze;
  assign id_exe_bubble  = ctrl_s.id_exe_bubble;
  assign exe_mem_freeze = ctrl_s.exe_mem_freeze;
  assign mem_wb_bubble  = ctrl_s.mem_wb_bubble;
  assign mem_timeout    = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Self-checking bench for pipeline_ctrl_unit: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_pipeline_ctrl_unit;

  localparam int T   = 8;
  localparam int W   = 4;
  localparam int MAX = 15;

  logic         clk = 1'b0;
  logic         rst, hazard_detected, branch_taken, mem_req, sram_ready, perf_clr;
  logic         pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_bubble;
  logic         exe_mem_freeze, mem_wb_bubble, mem_timeout;
  logic [W-1:0] stall_cnt, flush_cnt, memwait_cnt;

  int total = 0;
  int bad   = 0;

  // model state
  int       m_stall, m_flush, m_memwait, m_run;
  bit       m_to;
  logic [6:0] exp_ctrl;
  logic [6:0] ctrl;
  logic [12:0] regs, exp_regs;

  pipeline_ctrl_unit #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
    .perf_clr(perf_clr), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .if_id_flush(if_id_flush), .id_exe_freeze(id_exe_freeze),
    .id_exe_bubble(id_exe_bubble), .exe_mem_freeze(exe_mem_freeze),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze,
                 id_exe_bubble, exe_mem_freeze, mem_wb_bubble};
  assign regs = {mem_timeout, stall_cnt, flush_cnt, memwait_cnt};

  // Apply one cycle of inputs and compute the expected control vector.
  task automatic drive(input logic r, h, b, mr, sr, pc);
    @(negedge clk);
    rst = r; hazard_detected = h; branch_taken = b;
    mem_req = mr; sram_ready = sr; perf_clr = pc;
    if (r)             exp_ctrl = 7'b0000000;
    else if (mr && !sr) exp_ctrl = 7'b1101011;
    else if (b)        exp_ctrl = 7'b0010100;
    else if (h)        exp_ctrl = 7'b1100100;
    else               exp_ctrl = 7'b0000000;
    #1;
  endtask

  // Clock edge: advance the model with the inputs of the closing cycle.
  task automatic tick();
    bit stall;
    @(posedge clk);
    stall = mem_req && !sram_ready;
    if (rst) begin
      m_stall = 0; m_flush = 0; m_memwait = 0; m_run = 0; m_to = 0;
    end else begin
      if (stall) begin
        m_run++;
        if (m_run >= T) m_to = 1;
      end else begin
        m_run = 0;
      end
      if (perf_clr) begin
        m_stall = 0; m_flush = 0; m_memwait = 0;
      end else begin
        if (stall && m_memwait < MAX) m_memwait++;
        if (!stall && branch_taken && m_flush < MAX) m_flush++;
        if (!stall && !branch_taken && hazard_detected && m_stall < MAX) m_stall++;
      end
    end
    exp_regs = {m_to, 4'(m_stall), 4'(m_flush), 4'(m_memwait)};
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (ctrl !== 7'b0000000) begin
      $display("FAIL reset_ctrl: got %b want %b", ctrl, 7'b0000000); bad++;
    end
    tick();
    total++;
    if (regs !== 13'h0000) begin
      $display("FAIL reset_regs: got %h want %h", regs, 13'h0000); bad++;
    end
  endtask

  task automatic test_hazard();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (ctrl !== 7'b1100100) begin
        $display("FAIL hazard_ctrl: got %b want %b", ctrl, 7'b1100100); bad++;
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ctrl !== 7'b0000000) begin
      $display("FAIL hazard_release: got %b want %b", ctrl, 7'b0000000); bad++;
    end
    total++;
    if (stall_cnt !== 4'd2) begin
      $display("FAIL hazard_stall_cnt: got %0d want 2", stall_cnt); bad++;
    end
    tick();
  endtask

  task automatic test_branch_hazard();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (ctrl !== 7'b0010100) begin
      $display("FAIL branch_hazard_ctrl: got %b want %b", ctrl, 7'b0010100); bad++;
    end
    tick();
    total++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      $display("FAIL branch_hazard_cnt: got flush=%0d stall=%0d want 1 0",
               flush_cnt, stall_cnt); bad++;
    end
  endtask

  task automatic test_mem_branch();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if (ctrl !== 7'b1101011) begin
        $display("FAIL mem_wait_ctrl cyc%0d: got %b want %b", i, ctrl, 7'b1101011); bad++;
      end
      tick();
    end
    // Ready cycle: freeze drops and the deferred branch flush fires.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (ctrl !== 7'b0010100) begin
      $display("FAIL mem_ready_ctrl: got %b want %b", ctrl, 7'b0010100); bad++;
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ctrl !== 7'b0000000) begin
      $display("FAIL mem_after_ctrl: got %b want %b", ctrl, 7'b0000000); bad++;
    end
    total++;
    if (memwait_cnt !== 4'd5 || flush_cnt !== 4'd1) begin
      $display("FAIL mem_branch_cnt: got memwait=%0d flush=%0d want 5 1",
               memwait_cnt, flush_cnt); bad++;
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= T; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      total++;
      if (mem_timeout !== logic'(i == T)) begin
        $display("FAIL timeout_rise cyc%0d: got %b want %b", i, mem_timeout, i == T); bad++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (mem_timeout !== 1'b1) begin
      $display("FAIL timeout_sticky: got %b want 1", mem_timeout); bad++;
    end
    do_reset();
    total++;
    if (mem_timeout !== 1'b0) begin
      $display("FAIL timeout_clear: got %b want 0", mem_timeout); bad++;
    end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (ctrl !== 7'b0000000) begin
      $display("FAIL midwait_rst_ctrl: got %b want %b", ctrl, 7'b0000000); bad++;
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ctrl !== 7'b0000000 || regs !== 13'h0000) begin
      $display("FAIL midwait_after: got ctrl=%b regs=%h want 0 0", ctrl, regs); bad++;
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    total++;
    if (stall_cnt !== 4'd15) begin
      $display("FAIL sat_stall_cnt: got %0d want 15", stall_cnt); bad++;
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    total++;
    if (stall_cnt !== 4'd0) begin
      $display("FAIL perf_clr_priority: got %0d want 0", stall_cnt); bad++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(logic'($urandom_range(39) == 0), logic'($urandom_range(2) == 0),
            logic'($urandom_range(3) == 0), logic'($urandom_range(1) == 0),
            logic'($urandom_range(3) == 0), logic'($urandom_range(29) == 0));
      total++;
      if (ctrl !== exp_ctrl) begin
        $display("FAIL rand_ctrl cyc%0d: got %b want %b", i, ctrl, exp_ctrl); bad++;
      end
      tick();
      total++;
      if (regs !== exp_regs) begin
        $display("FAIL rand_regs cyc%0d: got %h want %h", i, regs, exp_regs); bad++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; sram_ready = 1'b0; perf_clr = 1'b0;
    m_stall = 0; m_flush = 0; m_memwait = 0; m_run = 0; m_to = 0;
    exp_ctrl = '0; exp_regs = '0;
    test_reset();
    test_hazard();
    test_branch_hazard();
    test_mem_branch();
    test_timeout();
    test_reset_midwait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
